// File: rtl/sdiv_issue.sv
// rtl/sdiv_issue.sv - credit-gated issue stage that queues signed-divide requests for sdiv
//
// Build option: define SDIV_ISSUE_SPECIAL_EN to compute the divide-by-zero and
// INT_MIN / -1 overflow flags for each issued operation. Without it both flags
// are tied to 0 and no comparators are built.
//
// Parameters
//   DEPTH    request FIFO entries (power of two, >= 2)
//   CREDITS  operations allowed in flight in sdiv plus its result buffer (>= 1)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_vld     upstream request valid
//   in_rdy     FIFO has room; a request is taken when in_vld && in_rdy
//   in_n       signed dividend
//   in_d       divisor
//   en         registered one-cycle issue strobe to sdiv
//   n          registered dividend, valid with en
//   d          registered divisor, valid with en
//   cred_ret   one-cycle credit return pulse from the result buffer
//   credits    credits currently available
//   spec_zero  issued operation has d == 0, valid with en
//   spec_ovf   issued operation is 0x80000000 / 0xFFFFFFFF, valid with en
//   err        sticky: credit returned while none were outstanding

module sdiv_issue #(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [31:0]                  in_n,
    input  logic [31:0]                  in_d,
    output logic                         en,
    output logic [31:0]                  n,
    output logic [31:0]                  d,
    input  logic                         cred_ret,
    output logic [$clog2(CREDITS+1)-1:0] credits,
    output logic                         spec_zero,
    output logic                         spec_ovf,
    output logic                         err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(CREDITS + 1);

    localparam logic [CW-1:0] FIFO_FULL   = CW'(DEPTH);
    localparam logic [KW-1:0] CREDITS_MAX = KW'(CREDITS);

    // Request storage; the data array carries no reset because occupancy
    // alone decides which entries are live.
    logic [31:0]   mem_n [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic [31:0]   head_n;
    logic [31:0]   head_d;

    logic [AW-1:0] wptr_nxt;
    logic [AW-1:0] rptr_nxt;
    logic [CW-1:0] count_nxt;
    logic [KW-1:0] credits_nxt;
    logic          err_nxt;

    // Readiness depends on occupancy only, so a full FIFO cannot take a push
    // on the same edge as a pop; room shows up one cycle later.
    assign in_rdy = (count < FIFO_FULL);
    assign push   = in_vld && in_rdy;

    // Issue uses pre-edge credits: a returning credit cannot be spent on the
    // edge it arrives.
    assign pop    = (count != '0) && (credits != '0);

    assign head_n = mem_n[rptr];
    assign head_d = mem_d[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_n[wptr] <= in_n;
            mem_d[wptr] <= in_d;
        end
    end

    always_comb begin
        wptr_nxt    = wptr;
        rptr_nxt    = rptr;
        count_nxt   = count;
        credits_nxt = credits;
        err_nxt     = err;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wptr_nxt = wptr + 1'b1;
        end
        if (pop) begin
            rptr_nxt = rptr + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase

        // An issue and a return on the same edge cancel out.
        if (pop && !cred_ret) begin
            credits_nxt = credits - 1'b1;
        end else if (cred_ret && !pop) begin
            if (credits == CREDITS_MAX) begin
                err_nxt = 1'b1;
            end else begin
                credits_nxt = credits + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            credits <= CREDITS_MAX;
            err     <= 1'b0;
            en      <= 1'b0;
            n       <= '0;
            d       <= '0;
        end else begin
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            count   <= count_nxt;
            credits <= credits_nxt;
            err     <= err_nxt;
            en      <= pop;
            // Operands hold between issues so sdiv sees stable inputs.
            if (pop) begin
                n <= head_n;
                d <= head_d;
            end
        end
    end

`ifdef SDIV_ISSUE_SPECIAL_EN
    logic head_zero;
    logic head_ovf;

    assign head_zero = (head_d == 32'h0000_0000);
    assign head_ovf  = (head_n == 32'h8000_0000) && (head_d == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_zero <= 1'b0;
            spec_ovf  <= 1'b0;
        end else if (pop) begin
            spec_zero <= head_zero;
            spec_ovf  <= head_ovf;
        end
    end
`else
    assign spec_zero = 1'b0;
    assign spec_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_sdiv_issue.sv
// tb/tb_sdiv_issue.sv - self-checking bench for sdiv_issue against a queue-based reference model

module tb_sdiv_issue;

    localparam int DEPTH   = 4;
    localparam int CREDITS = 8;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_n;
    logic [31:0] in_d;
    logic        en;
    logic [31:0] n;
    logic [31:0] d;
    logic        cred_ret;
    logic [3:0]  credits;
    logic        spec_zero;
    logic        spec_ovf;
    logic        err;

    int checks;
    int failures;

    // Reference model state
    logic [63:0] m_q[$];
    int          m_cred;
    bit          m_en;
    logic [31:0] m_n;
    logic [31:0] m_d;
    bit          m_sz;
    bit          m_ov;
    bit          m_err;
    bit          p_rdy;
    bit          p_rdy_exp;

    sdiv_issue #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_n      (in_n),
        .in_d      (in_d),
        .en        (en),
        .n         (n),
        .d         (d),
        .cred_ret  (cred_ret),
        .credits   (credits),
        .spec_zero (spec_zero),
        .spec_ovf  (spec_ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model by the same edge, and
    // return 1 ns after the edge with outputs settled.
    task automatic step(input bit v, input logic [31:0] nn, input logic [31:0] dd,
                        input bit cr, input bit r);
        bit          acc;
        bit          iss;
        logic [63:0] h;
        in_vld   = v;
        in_n     = nn;
        in_d     = dd;
        cred_ret = cr;
        rst      = r;
        #1;
        p_rdy     = in_rdy;
        p_rdy_exp = (m_q.size() < DEPTH);
        if (r) begin
            m_q.delete();
            m_cred = CREDITS;
            m_en   = 0;
            m_n    = '0;
            m_d    = '0;
            m_sz   = 0;
            m_ov   = 0;
            m_err  = 0;
        end else begin
            acc = v && (m_q.size() < DEPTH);
            iss = (m_q.size() > 0) && (m_cred > 0);
            m_en = iss;
            if (iss) begin
                h   = m_q.pop_front();
                m_n = h[63:32];
                m_d = h[31:0];
`ifdef SDIV_ISSUE_SPECIAL_EN
                m_sz = (m_d == 32'd0);
                m_ov = (m_n == 32'h8000_0000) && (m_d == 32'hFFFF_FFFF);
`else
                m_sz = 0;
                m_ov = 0;
`endif
            end
            if (acc) m_q.push_back({nn, dd});
            if (iss && !cr) m_cred = m_cred - 1;
            else if (cr && !iss) begin
                if (m_cred == CREDITS) m_err = 1;
                else m_cred = m_cred + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, '0, '0, 0, 0);
    endtask

    task automatic test_reset;
        step(1, 32'h1234, 32'h5, 1, 1);
        step(0, '0, '0, 0, 1);
        checks++;
        if ({en, n, d, spec_zero, spec_ovf, err} !== {1'b0, 32'h0, 32'h0, 3'b000}) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b n=%h d=%h sz=%b ov=%b err=%b, want all zero",
                     en, n, d, spec_zero, spec_ovf, err);
        end
        checks++;
        if (credits !== 4'd8 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_credits_rdy: got credits=%0d in_rdy=%b, want 8 and 1", credits, in_rdy);
        end
    endtask

    task automatic test_single;
        step(0, '0, '0, 0, 1);
        step(1, 32'hFFFF_FFEE, 32'd5, 0, 0);
        checks++;
        if (en !== 1'b0) begin
            failures++;
            $display("FAIL single_no_early_en: got en=%b want 0", en);
        end
        step(0, '0, '0, 0, 0);
        checks++;
        if ({en, n, d} !== {1'b1, 32'hFFFF_FFEE, 32'd5} || credits !== 4'd7) begin
            failures++;
            $display("FAIL single_issue: got en=%b n=%h d=%h credits=%0d want 1 ffffffee 5 7",
                     en, n, d, credits);
        end
        step(0, '0, '0, 0, 0);
        checks++;
        if (en !== 1'b0 || n !== 32'hFFFF_FFEE) begin
            failures++;
            $display("FAIL single_one_pulse: got en=%b n=%h want 0 ffffffee (held)", en, n);
        end
    endtask

    task automatic test_stream;
        int pulses;
        bit rdy_low;
        pulses  = 0;
        rdy_low = 0;
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            if (i < 6) step(1, $urandom, $urandom_range(1, 1000), 0, 0);
            else step(0, '0, '0, 0, 0);
            if (i < 6 && !p_rdy) rdy_low = 1;
            if (en) pulses++;
            checks++;
            if ({en, n, d} !== {m_en, m_n, m_d}) begin
                failures++;
                $display("FAIL stream_order[%0d]: got en=%b n=%h d=%h want en=%b n=%h d=%h",
                         i, en, n, d, m_en, m_n, m_d);
            end
        end
        checks++;
        if (pulses != 6 || rdy_low || credits !== 4'd2) begin
            failures++;
            $display("FAIL stream_summary: got pulses=%0d rdy_low=%b credits=%0d want 6 0 2",
                     pulses, rdy_low, credits);
        end
    endtask

    task automatic test_credit_exhaust;
        int pulses;
        pulses = 0;
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 14; i++) begin
            if (i < 10) step(1, $urandom, $urandom, 0, 0);
            else step(0, '0, '0, 0, 0);
            if (en) pulses++;
        end
        checks++;
        if (pulses != 8 || credits !== 4'd0 || m_q.size() != 2) begin
            failures++;
            $display("FAIL exhaust_count: got pulses=%0d credits=%0d model_q=%0d want 8 0 2",
                     pulses, credits, m_q.size());
        end
        step(0, '0, '0, 1, 0);
        checks++;
        if (en !== 1'b0 || credits !== 4'd1) begin
            failures++;
            $display("FAIL exhaust_no_bypass: got en=%b credits=%0d want 0 1", en, credits);
        end
        step(0, '0, '0, 0, 0);
        checks++;
        if (en !== 1'b1 || {n, d} !== {m_n, m_d} || credits !== 4'd0) begin
            failures++;
            $display("FAIL exhaust_release: got en=%b n=%h d=%h credits=%0d want 1 %h %h 0",
                     en, n, d, credits, m_n, m_d);
        end
        step(0, '0, '0, 0, 0);
        checks++;
        if (en !== 1'b0) begin
            failures++;
            $display("FAIL exhaust_single_release: got en=%b want 0", en);
        end
    endtask

    task automatic test_credit_same_edge;
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, $urandom, $urandom, 0, 0);
        idle(1);
        checks++;
        if (credits !== 4'd3) begin
            failures++;
            $display("FAIL same_edge_setup: got credits=%0d want 3", credits);
        end
        step(1, 32'd100, 32'd7, 0, 0);
        step(0, '0, '0, 1, 0);
        checks++;
        if (en !== 1'b1 || credits !== 4'd3) begin
            failures++;
            $display("FAIL same_edge_cancel: got en=%b credits=%0d want 1 3", en, credits);
        end
        for (int i = 0; i < 5; i++) step(0, '0, '0, 1, 0);
        checks++;
        if (credits !== 4'd8 || err !== 1'b0) begin
            failures++;
            $display("FAIL return_to_full: got credits=%0d err=%b want 8 0", credits, err);
        end
        step(0, '0, '0, 1, 0);
        idle(3);
        checks++;
        if (credits !== 4'd8 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got credits=%0d err=%b want 8 1", credits, err);
        end
        step(0, '0, '0, 0, 1);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_reset: got err=%b want 0", err);
        end
    endtask

    task automatic test_special;
        bit exp_on;
`ifdef SDIV_ISSUE_SPECIAL_EN
        exp_on = 1;
`else
        exp_on = 0;
`endif
        step(0, '0, '0, 0, 1);
        step(1, 32'd7, 32'd0, 0, 0);
        step(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        checks++;
        if ({en, spec_zero, spec_ovf} !== {1'b1, exp_on, 1'b0}) begin
            failures++;
            $display("FAIL special_zero: got en=%b sz=%b ov=%b want 1 %b 0", en, spec_zero, spec_ovf, exp_on);
        end
        step(1, 32'd9, 32'd3, 0, 0);
        checks++;
        if ({en, spec_zero, spec_ovf} !== {1'b1, 1'b0, exp_on}) begin
            failures++;
            $display("FAIL special_ovf: got en=%b sz=%b ov=%b want 1 0 %b", en, spec_zero, spec_ovf, exp_on);
        end
        step(0, '0, '0, 0, 0);
        checks++;
        if ({en, spec_zero, spec_ovf} !== 3'b100) begin
            failures++;
            $display("FAIL special_plain: got en=%b sz=%b ov=%b want 1 0 0", en, spec_zero, spec_ovf);
        end
    endtask

    task automatic test_full_reset;
        bit stale;
        stale = 0;
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 12; i++) step(1, $urandom, $urandom, 0, 0);
        step(1, 32'hDEAD, 32'hBEEF, 0, 0);
        checks++;
        if (p_rdy !== 1'b0 || credits !== 4'd0) begin
            failures++;
            $display("FAIL full_rdy_low: got in_rdy=%b credits=%0d want 0 0", p_rdy, credits);
        end
        step(1, 32'h1, 32'h1, 1, 1);
        checks++;
        if (in_rdy !== 1'b1 || en !== 1'b0 || credits !== 4'd8) begin
            failures++;
            $display("FAIL full_reset: got in_rdy=%b en=%b credits=%0d want 1 0 8", in_rdy, en, credits);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, '0, '0, 0, 0);
            if (en) stale = 1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("FAIL full_no_stale: got en pulse after reset, want none");
        end
    endtask

    task automatic test_random;
        bit          v;
        bit          cr;
        bit          r;
        logic [31:0] nn;
        logic [31:0] dd;
        int          sel;
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            cr  = (m_cred < CREDITS) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 29) == 0);
            r   = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 7);
            nn  = $urandom;
            dd  = $urandom;
            if (sel == 0) dd = 32'd0;
            if (sel == 1) begin
                nn = 32'h8000_0000;
                dd = 32'hFFFF_FFFF;
            end
            step(v, nn, dd, cr, r);
            checks++;
            if (p_rdy !== p_rdy_exp) begin
                failures++;
                $display("FAIL rand_rdy[%0d]: got %b want %b", i, p_rdy, p_rdy_exp);
            end
            checks++;
            if ({en, n, d, spec_zero, spec_ovf, err} !== {m_en, m_n, m_d, m_sz, m_ov, m_err}
                || credits !== 4'(m_cred)) begin
                failures++;
                $display("FAIL rand_out[%0d]: got en=%b n=%h d=%h sz=%b ov=%b err=%b cr=%0d want en=%b n=%h d=%h sz=%b ov=%b err=%b cr=%0d",
                         i, en, n, d, spec_zero, spec_ovf, err, credits,
                         m_en, m_n, m_d, m_sz, m_ov, m_err, m_cred);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1;
        in_vld   = 0;
        in_n     = '0;
        in_d     = '0;
        cred_ret = 0;
        test_reset;
        test_single;
        test_stream;
        test_credit_exhaust;
        test_credit_same_edge;
        test_special;
        test_full_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdiv_issue.md
SDIV_ISSUE -- requirements
Module: sdiv_issue

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO entries, power of two, at least 2.
REQ-002 Parameter CREDITS, default 8: maximum operations in flight in sdiv plus its result buffer, at least 1.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_vld  in  1  upstream request valid.
REQ-006 in_rdy  out  1  request accepted this edge when in_vld && in_rdy.
REQ-007 in_n  in  32  signed dividend.
REQ-008 in_d  in  32  divisor.
REQ-009 en  out  1  registered issue strobe to sdiv; one cycle high per issued operation.
REQ-010 n  out  32  registered dividend to sdiv; valid when en=1.
REQ-011 d  out  32  registered divisor to sdiv; valid when en=1.
REQ-012 cred_ret  in  1  one-cycle pulse from the downstream result buffer; returns one credit.
REQ-013 credits  out  $clog2(CREDITS+1)  credits currently available.
REQ-014 spec_zero  out  1  issued operation has d==0; valid with en.
REQ-015 spec_ovf  out  1  issued operation has n==32'h80000000 and d==32'hFFFFFFFF; valid with en.
REQ-016 err  out  1  sticky: a credit was returned when none were outstanding.

Function
REQ-017 in_rdy SHALL be 1 exactly when FIFO occupancy < DEPTH; it is combinational from occupancy only and never depends on in_vld.
REQ-018 An accepted request SHALL be written into the FIFO in arrival order; no bypass path exists.
REQ-019 Issue SHALL occur at an edge when the FIFO is non-empty and credits > 0 (pre-edge values): the head is popped, en<=1, n/d<=head, flags<=head checks.
REQ-020 At an edge with no issue, en SHALL be 0 and n, d, spec_zero, spec_ovf SHALL hold their previous values.
REQ-021 At most one issue per edge; with continuous requests and ample credits, throughput SHALL be one operation per cycle.
REQ-022 A request accepted at edge k on an empty FIFO SHALL cause en=1 in the cycle following edge k+1; this is the minimum latency.
REQ-023 Credit update: issue only -> -1; cred_ret only -> +1; both -> unchanged; neither -> unchanged.
REQ-024 When cred_ret arrives while credits==CREDITS and no issue occurs that edge, credits SHALL stay at CREDITS and err SHALL set to 1.
REQ-025 At credits==0, cred_ret at edge k SHALL allow an issue at edge k+1 at the earliest; there is no same-edge credit bypass.
REQ-026 Push and pop at the same edge on a non-full FIFO SHALL keep occupancy unchanged; pointers wrap modulo DEPTH.
REQ-027 A full FIFO SHALL accept a push only at the edge after a pop, because in_rdy reflects pre-edge occupancy.

Reset
REQ-028 On rst=1 at an edge, the block SHALL set: FIFO empty, credits=CREDITS, en=0, n=0, d=0, spec_zero=0, spec_ovf=0, err=0.
REQ-029 Reset mid-operation SHALL discard all queued requests; in_rdy=1 in the cycle after reset.
REQ-030 Reset SHALL take priority over accepts, issues and cred_ret at the same edge.

Configuration
REQ-031 With SDIV_ISSUE_SPECIAL_EN defined, spec_zero and spec_ovf SHALL be computed per REQ-014/015 and registered with each issue.
REQ-032 Without SDIV_ISSUE_SPECIAL_EN, spec_zero and spec_ovf SHALL be constant 0 and no comparator logic SHALL be synthesised; all other behaviour is unchanged.

Verification
REQ-033 Single request n=32'hFFFFFFEE, d=5 after reset -> en high exactly one cycle, 2 edges after accept, with n=FFFFFFEE, d=5; credits 8->7.
REQ-034 in_vld held high for 6 cycles, no cred_ret, CREDITS=8 -> 6 consecutive en pulses in order; in_rdy never low; credits ends at 2.
REQ-035 10 back-to-back requests, no cred_ret -> exactly 8 issues; FIFO holds 2; a single cred_ret releases exactly one more issue one edge later.
REQ-036 Issue and cred_ret at the same edge with credits=3 -> credits stays 3; cred_ret at credits=8 with idle FIFO -> err=1 until reset.
REQ-037 With SDIV_ISSUE_SPECIAL_EN: requests (7,0) and (80000000,FFFFFFFF) -> spec_zero=1, then spec_ovf=1, each with its en; without the macro, both flags stay 0.
REQ-038 Fill FIFO to DEPTH=4 with credits=0, then assert rst -> next cycle in_rdy=1, en=0, credits=8, and no stale entry is ever issued.
